// File: rtl/mux_striping_n.sv
// mux_striping_n: merges LANES parallel lane streams into one serialized
// word stream. Each lane has its own FIFO. A read pointer walks the active
// lanes and pops at most one FIFO per clock. There are two read modes:
//   - strict round-robin, which stalls on an empty lane;
//   - skip, which jumps to the next non-empty active lane.
//
// Ports:
//   clk_nf     - sole clock (N x lane rate), rising edge
//   reset      - asynchronous, active-high
//   lane_data  - LANES packed words, lane i at [i*WIDTH +: WIDTH]
//   lane_valid - per-lane push strobe
//   lane_cnt   - active link width; 0 -> 1, >LANES -> LANES
//   skip_mode  - 0 strict round-robin, 1 skip empty lanes
//   data_out   - registered serialized word
//   valid_out  - registered, high when data_out carries a new word
//   lane_sel   - registered source lane of data_out
//   lane_full  - per-lane FIFO full (registered-state decode)
//   overflow   - per-lane sticky drop flag
module mux_striping_n #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_nf,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] lane_data,
    input  logic [LANES-1:0]       lane_valid,
    input  logic [3:0]             lane_cnt,
    input  logic                   skip_mode,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic [2:0]             lane_sel,
    output logic [LANES-1:0]       lane_full,
    output logic [LANES-1:0]       overflow
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]    LANES4   = 4'(LANES);

    // Per-lane heads and occupancy, padded to 8 entries so that a 3-bit
    // lane index always lands inside the array.
    logic [WIDTH-1:0] head [8];
    logic [7:0]       occ;
    logic [LANES-1:0] pop;

    logic [2:0] ptr;
    logic [3:0] eff_cnt;
    logic [2:0] start;
    logic       pick_hit;
    logic [2:0] pick_lane;
    logic [3:0] sum;
    logic [3:0] nxt;

    always_comb begin
        if (lane_cnt == 4'd0)        eff_cnt = 4'd1;
        else if (lane_cnt > LANES4)  eff_cnt = LANES4;
        else                         eff_cnt = lane_cnt;
    end

    // A pointer stranded past a shrunken link width restarts at lane 0.
    assign start = ({1'b0, ptr} >= eff_cnt) ? 3'd0 : ptr;

    always_comb begin
        pick_hit  = 1'b0;
        pick_lane = start;
        sum       = 4'd0;
        if (!skip_mode) begin
            pick_hit = occ[start];
        end else begin
            // Walk offsets from farthest to nearest so the nearest
            // non-empty lane (in scan order from start) wins.
            for (int k = LANES - 1; k >= 0; k--) begin
                sum = {1'b0, start} + 4'(k);
                if (sum >= eff_cnt) sum = sum - eff_cnt;
                if (4'(k) < eff_cnt && occ[sum[2:0]]) begin
                    pick_hit  = 1'b1;
                    pick_lane = sum[2:0];
                end
            end
        end
    end

    always_comb begin
        nxt = {1'b0, pick_lane} + 4'd1;
        if (nxt >= eff_cnt) nxt = 4'd0;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    rd;
        logic [AW-1:0]    wr;
        logic [AW:0]      cnt;
        logic             full;
        logic             push;
        logic             ovf;

        assign full = (cnt == FULL_CNT);
        // A same-edge pop frees the slot, so a full FIFO can still accept.
        assign push = lane_valid[i] && (!full || pop[i]);
        assign pop[i] = pick_hit && (pick_lane == 3'(i));

        assign head[i]      = mem[rd];
        assign occ[i]       = (cnt != '0);
        assign lane_full[i] = full;
        assign overflow[i]  = ovf;

        always_ff @(posedge clk_nf) begin
            if (push) mem[wr] <= lane_data[i*WIDTH +: WIDTH];
        end

        always_ff @(posedge clk_nf or posedge reset) begin
            if (reset) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (push)   wr <= wr + 1'b1;
                if (pop[i]) rd <= rd + 1'b1;
                if (push && !pop[i])      cnt <= cnt + 1'b1;
                else if (!push && pop[i]) cnt <= cnt - 1'b1;
                if (lane_valid[i] && full && !pop[i]) ovf <= 1'b1;
            end
        end
    end

    for (genvar j = LANES; j < 8; j++) begin : g_pad
        assign head[j] = '0;
        assign occ[j]  = 1'b0;
    end

    always_ff @(posedge clk_nf or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_sel  <= 3'd0;
            ptr       <= 3'd0;
        end else begin
            valid_out <= pick_hit;
            if (pick_hit) begin
                data_out <= head[pick_lane];
                lane_sel <= pick_lane;
                ptr      <= nxt[2:0];
            end
        end
    end
endmodule

// File: tb/tb_mux_striping_n.sv
// Self-checking bench for mux_striping_n. The bench has three parts:
//   - a table of vectors for the basic two-lane interleave;
//   - hand-written sequences for stall/skip, overflow, width shrink and
//     asynchronous reset;
//   - a randomized phase checked against a queue-based reference model.
module tb_mux_striping_n;
    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk_nf = 1'b0;
    logic                   reset  = 1'b1;
    logic [LANES*WIDTH-1:0] lane_data  = '0;
    logic [LANES-1:0]       lane_valid = '0;
    logic [3:0]             lane_cnt   = 4'd4;
    logic                   skip_mode  = 1'b0;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic [2:0]             lane_sel;
    logic [LANES-1:0]       lane_full;
    logic [LANES-1:0]       overflow;

    mux_striping_n #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_nf(clk_nf), .reset(reset), .lane_data(lane_data),
        .lane_valid(lane_valid), .lane_cnt(lane_cnt), .skip_mode(skip_mode),
        .data_out(data_out), .valid_out(valid_out), .lane_sel(lane_sel),
        .lane_full(lane_full), .overflow(overflow)
    );

    always #5 clk_nf = ~clk_nf;

    int checks = 0;
    int failures = 0;

    // Reference model: one queue per lane plus the read pointer.
    logic [WIDTH-1:0] mq [LANES][$];
    int               m_ptr;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    int               m_sel;
    logic [LANES-1:0] m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) mq[i].delete();
        m_ptr = 0; m_data = '0; m_valid = 1'b0; m_sel = 0; m_ovf = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        int eff, p, hit;
        eff = (lane_cnt == 0) ? 1 : ((int'(lane_cnt) > LANES) ? LANES : int'(lane_cnt));
        p = (m_ptr >= eff) ? 0 : m_ptr;
        hit = -1;
        if (!skip_mode) begin
            if (mq[p].size() > 0) hit = p;
        end else begin
            for (int k = 0; k < eff; k++)
                if (hit < 0 && mq[(p + k) % eff].size() > 0) hit = (p + k) % eff;
        end
        if (hit >= 0) begin
            m_data  = mq[hit].pop_front();
            m_valid = 1'b1;
            m_sel   = hit;
            m_ptr   = (hit + 1 >= eff) ? 0 : hit + 1;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(lane_data[i*WIDTH +: WIDTH]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [LANES-1:0] exp_full;
        for (int i = 0; i < LANES; i++) exp_full[i] = (mq[i].size() == DEPTH);
        chk("model_valid", 32'(valid_out), 32'(m_valid));
        chk("model_data", data_out, m_data);
        chk("model_sel", 32'(lane_sel), 32'(m_sel));
        chk("model_full", 32'(lane_full), 32'(exp_full));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_step();
        @(posedge clk_nf);
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
        lane_valid = v;
        lane_data  = {d3, d2, d1, d0};
    endtask

    task automatic idle();
        set_in(4'b0000, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] d,
                              input logic [2:0] s);
        chk({name, "_valid"}, 32'(valid_out), 32'(v));
        if (v) begin
            chk({name, "_data"}, data_out, d);
            chk({name, "_sel"}, 32'(lane_sel), 32'(s));
        end
    endtask

    // Pulse reset between edges and check the asynchronous clear.
    task automatic reset_mid();
        #2 reset = 1'b1;
        #1;
        chk("rst_data", data_out, 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_sel", 32'(lane_sel), 32'h0);
        chk("rst_full", 32'(lane_full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        #1 reset = 1'b0;
        model_reset();
        idle();
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  es;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{4'b0011, 32'hAAAAAAAA, 32'hEEEEEEEE, 1'b0, 32'h0,        3'd0};
        tbl[1] = '{4'b0011, 32'hCCCCCCCC, 32'h99999999, 1'b1, 32'hAAAAAAAA, 3'd0};
        tbl[2] = '{4'b0000, 32'h0,        32'h0,        1'b1, 32'hEEEEEEEE, 3'd1};
        tbl[3] = '{4'b0000, 32'h0,        32'h0,        1'b1, 32'hCCCCCCCC, 3'd0};
        tbl[4] = '{4'b0000, 32'h0,        32'h0,        1'b1, 32'h99999999, 3'd1};
        tbl[5] = '{4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        3'd0};

        model_reset();
        #2;
        chk("reset_data", data_out, 32'h0);
        chk("reset_valid", 32'(valid_out), 32'h0);
        chk("reset_sel", 32'(lane_sel), 32'h0);
        chk("reset_full", 32'(lane_full), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);
        #5 reset = 1'b0;

        // Two-lane strict interleave
        lane_cnt = 4'd2; skip_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(tbl[i].valid, tbl[i].d0, tbl[i].d1, 0, 0);
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es);
        end

        // Strict stall on a never-pushed lane 2
        reset_mid();
        lane_cnt = 4'd4; skip_mode = 1'b0;
        set_in(4'b1011, 32'h10000000, 32'h11111111, 0, 32'h33333333); step();
        expect_out("strict_s1", 1'b0, 0, 0);
        idle(); step(); expect_out("strict_l0", 1'b1, 32'h10000000, 3'd0);
        step(); expect_out("strict_l1", 1'b1, 32'h11111111, 3'd1);
        step(); expect_out("strict_stall_a", 1'b0, 0, 0);
        step(); expect_out("strict_stall_b", 1'b0, 0, 0);
        set_in(4'b0100, 0, 0, 32'h22222222, 0); step();
        expect_out("strict_fill_edge", 1'b0, 0, 0);
        idle(); step(); expect_out("strict_l2", 1'b1, 32'h22222222, 3'd2);
        step(); expect_out("strict_l3", 1'b1, 32'h33333333, 3'd3);

        // Same traffic in skip mode: lane 3 does not wait for lane 2
        reset_mid();
        lane_cnt = 4'd4; skip_mode = 1'b1;
        set_in(4'b1011, 32'h10000000, 32'h11111111, 0, 32'h33333333); step();
        idle(); step(); expect_out("skip_l0", 1'b1, 32'h10000000, 3'd0);
        step(); expect_out("skip_l1", 1'b1, 32'h11111111, 3'd1);
        step(); expect_out("skip_l3", 1'b1, 32'h33333333, 3'd3);
        step(); expect_out("skip_empty", 1'b0, 0, 0);

        // Width shrink from 4 to 2 while ptr sits at 3
        reset_mid();
        lane_cnt = 4'd4; skip_mode = 1'b0;
        set_in(4'b1111, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3); step();
        set_in(4'b0011, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 0); step();
        expect_out("shrink_l0", 1'b1, 32'hA0A0A0A0, 3'd0);
        idle(); step(); expect_out("shrink_l1", 1'b1, 32'hB1B1B1B1, 3'd1);
        step(); expect_out("shrink_l2", 1'b1, 32'hC2C2C2C2, 3'd2);
        lane_cnt = 4'd2;
        step(); expect_out("shrink_wrap", 1'b1, 32'hA1A1A1A1, 3'd0);
        step(); expect_out("shrink_next", 1'b1, 32'hB2B2B2B2, 3'd1);
        step(); expect_out("shrink_no_l3", 1'b0, 0, 0);

        // Overflow on an inactive lane, then async reset with data held
        reset_mid();
        lane_cnt = 4'd1; skip_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            set_in(4'b0010, 0, 32'h50 + 32'(k), 0, 0);
            step();
            if (k == 4) begin
                chk("ovf_full_at4", 32'(lane_full), 32'h2);
                chk("ovf_clear_at4", 32'(overflow), 32'h0);
            end
        end
        chk("ovf_set_at5", 32'(overflow), 32'h2);
        chk("ovf_full_at5", 32'(lane_full), 32'h2);
        idle();
        reset_mid();
        lane_cnt = 4'd4;
        set_in(4'b0001, 32'h12345678, 0, 0, 0); step();
        expect_out("post_rst_fill", 1'b0, 0, 0);
        idle(); step(); expect_out("post_rst_new", 1'b1, 32'h12345678, 3'd0);
        step(); expect_out("post_rst_discard", 1'b0, 0, 0);

        // Randomized traffic against the model
        reset_mid();
        for (int c = 0; c < 600; c++) begin
            if (c % 23 == 0) lane_cnt = 4'($urandom_range(0, 15));
            if (c % 41 == 0) skip_mode = 1'($urandom_range(0, 1));
            lane_valid = 4'($urandom) & 4'($urandom | $urandom);
            lane_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
